// File: rtl/rom_arbiter_if.sv
// Fetch and data read channels plus the shared combinational ROM port.
interface rom_arbiter_if;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_valid;
    logic [DW-1:0] f_data;
    logic          f_misalign;
    logic          f_ready;
    logic          flush;

    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          d_gnt;
    logic          d_valid;
    logic [DW-1:0] d_data;
    logic          d_ready;

    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;

    modport slave (
        input  f_req, f_addr, f_ready, flush,
        input  d_req, d_addr, d_ready,
        input  rom_data,
        output f_gnt, f_valid, f_data, f_misalign,
        output d_gnt, d_valid, d_data,
        output rom_addr
    );

    modport master (
        output f_req, f_addr, f_ready, flush,
        output d_req, d_addr, d_ready,
        output rom_data,
        input  f_gnt, f_valid, f_data, f_misalign,
        input  d_gnt, d_valid, d_data,
        input  rom_addr
    );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter for the program ROM read port with a single registered,
// handshaked response slot shared by the fetch and data paths.
module rom_arbiter (
    input  logic          clk,
    input  logic          rst_n,
    rom_arbiter_if.slave  bus
);
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam logic LAST_F = 1'b0;
    localparam logic LAST_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        F_RSP = 2'd1,
        D_RSP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last;
    logic [DW-1:0] rsp;
    logic          misalign;

    logic          consumed;
    logic          open;
    logic          f_elig;
    logic          d_elig;
    logic          f_win;
    logic          d_win;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A flush counts as consuming a held fetch response so the slot frees up.
    always_comb begin
        state_nxt = state;
        consumed  = 1'b0;
        open      = 1'b0;
        f_elig    = 1'b0;
        d_elig    = 1'b0;
        f_win     = 1'b0;
        d_win     = 1'b0;

        case (state)
            F_RSP:   consumed = bus.flush | bus.f_ready;
            D_RSP:   consumed = bus.d_ready;
            default: consumed = 1'b0;
        endcase

        open   = (state == IDLE) | consumed;
        f_elig = rst_n & bus.f_req & ~bus.flush;
        d_elig = rst_n & bus.d_req;

        if (open) begin
            if (f_elig && d_elig) begin
                f_win = (last == LAST_D);
                d_win = (last == LAST_F);
            end else begin
                f_win = f_elig;
                d_win = d_elig;
            end
        end

        if (f_win) begin
            state_nxt = F_RSP;
        end else if (d_win) begin
            state_nxt = D_RSP;
        end else if (consumed) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last     <= LAST_D;
            rsp      <= '0;
            misalign <= 1'b0;
        end else begin
            if (f_win || d_win) begin
                rsp  <= bus.rom_data;
                last <= d_win ? LAST_D : LAST_F;
            end
            if (f_win) begin
                misalign <= bus.f_addr[0];
            end
        end
    end

    assign bus.f_gnt      = f_win;
    assign bus.d_gnt      = d_win;
    assign bus.rom_addr   = f_win ? bus.f_addr : (d_win ? bus.d_addr : AW'(0));
    assign bus.f_valid    = rst_n & (state == F_RSP) & ~bus.flush;
    assign bus.d_valid    = rst_n & (state == D_RSP);
    assign bus.f_data     = rsp;
    assign bus.d_data     = rsp;
    assign bus.f_misalign = misalign;
endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: stimulus queues expected responses, a monitor
// pops and compares them whenever a response is accepted.
module tb_rom_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    typedef struct packed {
        logic [15:0] d;
        logic        m;
    } fexp_t;

    fexp_t       fq[$];
    logic [15:0] dq[$];

    rom_arbiter_if bus ();

    rom_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program ROM image: only a few words are mapped, everything else reads 0.
    always_comb begin
        case (bus.rom_addr)
            16'd60:  bus.rom_data = 16'h8103;
            16'd62:  bus.rom_data = 16'hC100;
            16'd70:  bus.rom_data = 16'h8207;
            default: bus.rom_data = 16'h0000;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fr, input logic [15:0] fa, input logic frdy,
                         input logic fl, input logic dr, input logic [15:0] da,
                         input logic drdy);
        bus.f_req   = fr;
        bus.f_addr  = fa;
        bus.f_ready = frdy;
        bus.flush   = fl;
        bus.d_req   = dr;
        bus.d_addr  = da;
        bus.d_ready = drdy;
    endtask

    task automatic cycle(input string nm, input logic efg, input logic edg,
                         input logic efv, input logic edv,
                         input logic fpush, input logic [15:0] efd, input logic efm,
                         input logic dpush, input logic [15:0] edd);
        fexp_t e;
        logic [15:0] ea;
        @(negedge clk);
        ea = efg ? bus.f_addr : (edg ? bus.d_addr : 16'h0000);
        chk({nm, "_fgnt"},  32'(bus.f_gnt),   32'(efg));
        chk({nm, "_dgnt"},  32'(bus.d_gnt),   32'(edg));
        chk({nm, "_fval"},  32'(bus.f_valid), 32'(efv));
        chk({nm, "_dval"},  32'(bus.d_valid), 32'(edv));
        chk({nm, "_raddr"}, 32'(bus.rom_addr), 32'(ea));
        if (fpush) begin
            e.d = efd;
            e.m = efm;
            fq.push_back(e);
        end
        if (dpush) dq.push_back(edd);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, 16'd60, 1'b0, 1'b0, 1'b1, 16'd70, 1'b0);
        cycle("rst0", 0, 0, 0, 0, 0, 16'h0, 0, 0, 16'h0);
        cycle("rst1", 0, 0, 0, 0, 0, 16'h0, 0, 0, 16'h0);
        rst_n = 1'b1;
        drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        cycle("post_rst", 0, 0, 0, 0, 0, 16'h0, 0, 0, 16'h0);
    endtask

    // Monitor: any accepted response must match the oldest expectation.
    always @(negedge clk) begin
        fexp_t e;
        if (bus.f_valid && bus.f_ready) begin
            if (fq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL f_unexpected actual=%0h required=none t=%0t", bus.f_data, $time);
            end else begin
                e = fq.pop_front();
                chk("f_data", 32'(bus.f_data), 32'(e.d));
                chk("f_misalign", 32'(bus.f_misalign), 32'(e.m));
            end
        end
        if (bus.d_valid && bus.d_ready) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d_unexpected actual=%0h required=none t=%0t", bus.d_data, $time);
            end else begin
                chk("d_data", 32'(bus.d_data), 32'(dq.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        @(posedge clk);
        #1;
        do_reset();

        // Single fetch after reset
        drive(1'b1, 16'd60, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        cycle("f1", 1, 0, 0, 0, 1, 16'h8103, 0, 0, 16'h0);
        drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        cycle("f1_rsp", 0, 0, 1, 0, 0, 16'h0, 0, 0, 16'h0);

        // Contention from reset: fetch wins the first tie, then alternate
        do_reset();
        drive(1'b1, 16'd62, 1'b1, 1'b0, 1'b1, 16'd70, 1'b1);
        cycle("rr0", 1, 0, 0, 0, 1, 16'hC100, 0, 0, 16'h0);
        cycle("rr1", 0, 1, 1, 0, 0, 16'h0, 0, 1, 16'h8207);
        cycle("rr2", 1, 0, 0, 1, 1, 16'hC100, 0, 0, 16'h0);
        cycle("rr3", 0, 1, 1, 0, 0, 16'h0, 0, 1, 16'h8207);
        drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        cycle("rr_end", 0, 0, 0, 1, 0, 16'h0, 0, 0, 16'h0);

        // Backpressure on fetch stalls the data requester
        drive(1'b1, 16'd60, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        cycle("bp_g", 1, 0, 0, 0, 1, 16'h8103, 0, 0, 16'h0);
        drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 16'd70, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle("bp_stall", 0, 0, 1, 0, 0, 16'h0, 0, 0, 16'h0);
            chk("bp_hold_data", 32'(bus.f_data), 32'h8103);
            chk("bp_hold_mis", 32'(bus.f_misalign), 32'h0);
        end
        bus.f_ready = 1'b1;
        cycle("bp_rel", 0, 1, 1, 0, 0, 16'h0, 0, 1, 16'h8207);
        drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        cycle("bp_end", 0, 0, 0, 1, 0, 16'h0, 0, 0, 16'h0);

        // Flush drops the held fetch; regrant with f_ready=0 proves state is IDLE
        drive(1'b1, 16'd62, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        cycle("fl_g", 1, 0, 0, 0, 0, 16'h0, 0, 0, 16'h0);
        bus.flush = 1'b1;
        cycle("fl_on", 0, 0, 0, 0, 0, 16'h0, 0, 0, 16'h0);
        bus.flush = 1'b0;
        cycle("fl_regnt", 1, 0, 0, 0, 1, 16'hC100, 0, 0, 16'h0);
        drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        cycle("fl_rsp", 0, 0, 1, 0, 0, 16'h0, 0, 0, 16'h0);

        // Misaligned, unmapped fetch
        drive(1'b1, 16'd63, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        cycle("mis_g", 1, 0, 0, 0, 1, 16'h0000, 1, 0, 16'h0);
        drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        cycle("mis_rsp", 0, 0, 1, 0, 0, 16'h0, 0, 0, 16'h0);

        // Reset while a data response is held discards it
        drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 16'd70, 1'b0);
        cycle("mr_g", 0, 1, 0, 0, 0, 16'h0, 0, 0, 16'h0);
        drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        cycle("mr_hold", 0, 0, 0, 1, 0, 16'h0, 0, 0, 16'h0);
        do_reset();
        drive(1'b1, 16'd60, 1'b1, 1'b0, 1'b1, 16'd70, 1'b1);
        cycle("mr_tie0", 1, 0, 0, 0, 1, 16'h8103, 0, 0, 16'h0);
        cycle("mr_tie1", 0, 1, 1, 0, 0, 16'h0, 0, 1, 16'h8207);
        drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        cycle("mr_end", 0, 0, 0, 1, 0, 16'h0, 0, 0, 16'h0);

        @(negedge clk);
        chk("fq_drained", 32'(fq.size()), 32'd0);
        chk("dq_drained", 32'(dq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
